// File: rtl/ising_loader_pkg.sv
// Shared types for the Ising L1 AXI loader: FSM states, AXI4 channel structs, burst sizing helper.
// Pure declarations; no timing or backpressure of its own.
package ising_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        AR,
        RD,
        DONE
    } loader_state_e;

    localparam int unsigned PageBytes    = 4096;
    localparam int unsigned AxiAddrWidth = 48;
    localparam int unsigned AxiDataWidth = 64;
    localparam int unsigned AxiIdWidth   = 2;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
    } axi_ax_t;

    typedef struct packed {
        logic [AxiDataWidth-1:0]   data;
        logic [AxiDataWidth/8-1:0] strb;
        logic                      last;
    } axi_w_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0] id;
        logic [1:0]            resp;
    } axi_b_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_rsp_t;

    // Beats in the next burst: capped by max length, words left, and the distance to the 4 KiB page end.
    function automatic int unsigned burst_beats(input logic [11:0]  page_off,
                                                input int unsigned remaining,
                                                input int unsigned max_len,
                                                input int unsigned beat_bytes);
        int unsigned to_page;
        int unsigned beats;
        to_page = (PageBytes - 32'(page_off)) / beat_bytes;
        beats   = max_len;
        if (remaining < beats) beats = remaining;
        if (to_page < beats)   beats = to_page;
        return beats;
    endfunction

endpackage

// File: rtl/ising_l1_axi_loader.sv
// AXI4 read-burst initiator copying a contiguous block into Ising L1; one burst in flight, R beats pass straight to L1.
// Latency: AR one cycle after start; R->L1 combinational, 1 beat/cycle; L1 grant backpressures R via r_ready.
module ising_l1_axi_loader
    import ising_loader_pkg::*;
#(
    parameter int unsigned AddrWidth    = 48,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned IdWidth      = 2,
    parameter int unsigned MemAddrWidth = 16,
    parameter int unsigned MaxBurstLen  = 16,
    parameter type         axi_req_t    = ising_loader_pkg::axi_req_t,
    parameter type         axi_rsp_t    = ising_loader_pkg::axi_rsp_t
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [AddrWidth-1:0]    src_addr_i,
    input  logic [MemAddrWidth-1:0] dst_addr_i,
    input  logic [MemAddrWidth-1:0] num_beats_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output axi_req_t                axi_m_req_o,
    input  axi_rsp_t                axi_m_rsp_i,
    output logic                    mem_req_o,
    output logic [MemAddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    output logic                    mem_we_o,
    input  logic                    mem_gnt_i
);

    localparam int unsigned BeatBytes = DataWidth / 8;
    localparam int unsigned BeatShift = $clog2(BeatBytes);

    loader_state_e           r_state;
    logic [AddrWidth-1:0]    r_src;
    logic [MemAddrWidth-1:0] r_dst;
    logic [MemAddrWidth-1:0] r_rem;
    logic [7:0]              r_ar_len;
    logic [7:0]              r_beat_cnt;
    logic                    r_ar_valid;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;

    logic [AddrWidth-1:0]    w_src_aligned;
    logic [AddrWidth-1:0]    w_src_next;
    logic [MemAddrWidth-1:0] w_rem_next;
    logic                    w_rd_hs;
    int unsigned             w_beats_new;
    int unsigned             w_beats_cont;
    logic                    w_unused;

    assign w_src_aligned = {src_addr_i[AddrWidth-1:BeatShift], BeatShift'(0)};
    assign w_src_next    = r_src + AddrWidth'(BeatBytes);
    assign w_rem_next    = r_rem - MemAddrWidth'(1);
    assign w_rd_hs       = (r_state == RD) & axi_m_rsp_i.r_valid & mem_gnt_i;
    assign w_beats_new   = burst_beats(w_src_aligned[11:0], 32'(num_beats_i), MaxBurstLen, BeatBytes);
    assign w_beats_cont  = burst_beats(w_src_next[11:0], 32'(w_rem_next), MaxBurstLen, BeatBytes);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_src      <= '0;
            r_dst      <= '0;
            r_rem      <= '0;
            r_ar_len   <= '0;
            r_beat_cnt <= '0;
            r_ar_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        r_src  <= w_src_aligned;
                        r_dst  <= dst_addr_i;
                        r_rem  <= num_beats_i;
                        if (num_beats_i != '0) begin
                            r_ar_len   <= 8'(w_beats_new - 1);
                            r_ar_valid <= 1'b1;
                            r_state    <= AR;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                AR: begin
                    if (axi_m_rsp_i.ar_ready) begin
                        r_ar_valid <= 1'b0;
                        r_beat_cnt <= '0;
                        r_state    <= RD;
                    end
                end
                RD: begin
                    if (w_rd_hs) begin
                        r_src      <= w_src_next;
                        r_dst      <= r_dst + MemAddrWidth'(1);
                        r_rem      <= w_rem_next;
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (axi_m_rsp_i.r.resp[1]) r_err <= 1'b1;
                        if (axi_m_rsp_i.r.last) begin
                            if (w_rem_next == '0) begin
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end else begin
                                // r_src already points at the next burst start
                                r_ar_len   <= 8'(w_beats_cont - 1);
                                r_ar_valid <= 1'b1;
                                r_state    <= AR;
                            end
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        axi_m_req_o          = '0;
        axi_m_req_o.b_ready  = 1'b1;
        axi_m_req_o.ar.id    = IdWidth'(0);
        axi_m_req_o.ar.addr  = r_src;
        axi_m_req_o.ar.len   = r_ar_len;
        axi_m_req_o.ar.size  = 3'(BeatShift);
        axi_m_req_o.ar.burst = 2'b01;
        axi_m_req_o.ar_valid = r_ar_valid;
        axi_m_req_o.r_ready  = (r_state == RD) & mem_gnt_i;
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign mem_req_o   = (r_state == RD) & axi_m_rsp_i.r_valid;
    assign mem_addr_o  = r_dst;
    assign mem_wdata_o = axi_m_rsp_i.r.data;
    assign mem_we_o    = 1'b1;

    assign w_unused = ^{axi_m_rsp_i.aw_ready, axi_m_rsp_i.w_ready, axi_m_rsp_i.b_valid,
                        axi_m_rsp_i.b, axi_m_rsp_i.r.id, axi_m_rsp_i.r.resp[0]};

    a_r_only_in_rd: assert property (@(posedge clk_i) disable iff (!rst_ni)
        axi_m_rsp_i.r_valid |-> (r_state == RD));
    a_last_on_final: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_rd_hs |-> (axi_m_rsp_i.r.last == (r_beat_cnt == r_ar_len)));

endmodule
